// File: rtl/wvb_rdout_arbiter_if.sv
// Signal bundle between the waveform-buffer channels, the readout arbiter and the
// shared wvb_reader. master = arbiter side, slave = channels plus reader side.
interface wvb_rdout_arbiter_if #(
  parameter int N_CHAN = 4,
  parameter int HDR_W  = 80,
  parameter int DATA_W = 22
);
  logic [N_CHAN-1:0]        ch_hdr_empty;
  logic [N_CHAN*HDR_W-1:0]  ch_hdr_data;
  logic [N_CHAN*DATA_W-1:0] ch_wvb_data;
  logic [N_CHAN-1:0]        ch_hdr_rdreq;
  logic [N_CHAN-1:0]        ch_wvb_rdreq;
  logic [N_CHAN-1:0]        ch_wvb_rddone;

  logic                     rdr_hdr_empty;
  logic [HDR_W-1:0]         rdr_hdr_data;
  logic [DATA_W-1:0]        rdr_wvb_data;
  logic                     rdr_hdr_rdreq;
  logic                     rdr_wvb_rdreq;
  logic                     rdr_wvb_rddone;

  modport master (
    input  ch_hdr_empty, ch_hdr_data, ch_wvb_data,
    input  rdr_hdr_rdreq, rdr_wvb_rdreq, rdr_wvb_rddone,
    output ch_hdr_rdreq, ch_wvb_rdreq, ch_wvb_rddone,
    output rdr_hdr_empty, rdr_hdr_data, rdr_wvb_data
  );

  modport slave (
    output ch_hdr_empty, ch_hdr_data, ch_wvb_data,
    output rdr_hdr_rdreq, rdr_wvb_rdreq, rdr_wvb_rddone,
    input  ch_hdr_rdreq, ch_wvb_rdreq, ch_wvb_rddone,
    input  rdr_hdr_empty, rdr_hdr_data, rdr_wvb_data
  );
endinterface

// File: rtl/wvb_rdout_arbiter.sv
// Round-robin arbiter sharing one wvb_reader among N_CHAN waveform buffers.
// Optional per-channel grant counters on output grant_cnt_o when WVB_ARB_GRANT_CNT_EN is defined.
module wvb_rdout_arbiter #(
  parameter int N_CHAN = 4,
  parameter int HDR_W  = 80,
  parameter int DATA_W = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  wvb_rdout_arbiter_if.master        bus,
  output logic [2:0]                 sel_chan_o,
  output logic                       busy_o
`ifdef WVB_ARB_GRANT_CNT_EN
  ,
  output logic [N_CHAN*16-1:0]       grant_cnt_o
`endif
);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] rr_q, rr_d;
  logic [1:0] ready_q;
  logic [2:0] next_chan;
  logic       any_req;
  logic       grant;

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_CHAN) s = s - N_CHAN;
    return 3'(s);
  endfunction

  // Reset asserts asynchronously but releases through two flops, so grants resume cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= '0;
    else     ready_q <= {ready_q[0], 1'b1};
  end

  // Lowest rotation offset from rr_q wins, hence the descending loop.
  always_comb begin
    next_chan = rr_q;
    for (int k = N_CHAN - 1; k >= 0; k--) begin
      if (!bus.ch_hdr_empty[wrap_idx(rr_q, k)]) next_chan = wrap_idx(rr_q, k);
    end
  end

  assign any_req = ~&bus.ch_hdr_empty;
  assign grant   = (state_q == IDLE) && en_i && ready_q[1] && any_req;

  // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = LOCK;
          sel_d   = next_chan;
        end
      end
      LOCK: begin
        if (bus.rdr_wvb_rddone) begin
          state_d = IDLE;
          rr_d    = wrap_idx(sel_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  end

  // Data follows sel_q unconditionally; strobes and empty flag only pass while locked.
  always_comb begin
    bus.rdr_hdr_data  = '0;
    bus.rdr_wvb_data  = '0;
    bus.rdr_hdr_empty = 1'b1;
    bus.ch_hdr_rdreq  = '0;
    bus.ch_wvb_rdreq  = '0;
    bus.ch_wvb_rddone = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (sel_q == 3'(i)) begin
        bus.rdr_hdr_data = bus.ch_hdr_data[i*HDR_W +: HDR_W];
        bus.rdr_wvb_data = bus.ch_wvb_data[i*DATA_W +: DATA_W];
        if (state_q == LOCK) begin
          bus.rdr_hdr_empty     = bus.ch_hdr_empty[i];
          bus.ch_hdr_rdreq[i]   = bus.rdr_hdr_rdreq;
          bus.ch_wvb_rdreq[i]   = bus.rdr_wvb_rdreq;
          bus.ch_wvb_rddone[i]  = bus.rdr_wvb_rddone;
        end
      end
    end
  end

  assign sel_chan_o = sel_q;
  assign busy_o     = (state_q == LOCK);

`ifdef WVB_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt_q [N_CHAN];

  // NOTE: the counter array is ordinary flops, not RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CHAN; i++) grant_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (grant && (next_chan == 3'(i)) && (grant_cnt_q[i] != 16'hFFFF))
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_CHAN; g++) begin : g_cnt_out
    assign grant_cnt_o[g*16 +: 16] = grant_cnt_q[g];
  end
`endif

endmodule

// File: doc/wvb_rdout_arbiter.md
WVB_RDOUT_ARBITER -- requirements
Module: wvb_rdout_arbiter

Interface
REQ-001 Parameter N_CHAN, default 4, number of waveform buffer channels sharing one wvb_reader (2..8).
REQ-002 Parameter HDR_W, default 80, header word width.
REQ-003 Parameter DATA_W, default 22, waveform data word width.
REQ-004 clk  input  1  logic clock, 100 MHz lclk domain; the block uses this one clock only.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  grant enable; low blocks new grants, an in-progress transaction completes.
REQ-007 ch_hdr_empty  input  N_CHAN  per-channel header FIFO empty flags.
REQ-008 ch_hdr_data  input  N_CHAN*HDR_W  per-channel header words, channel i at [i*HDR_W +: HDR_W].
REQ-009 ch_wvb_data  input  N_CHAN*DATA_W  per-channel waveform words.
REQ-010 ch_hdr_rdreq, ch_wvb_rdreq, ch_wvb_rddone  output  N_CHAN each  per-channel read strobes.
REQ-011 rdr_hdr_empty  output  1  empty flag presented to wvb_reader.
REQ-012 rdr_hdr_data  output  HDR_W; rdr_wvb_data  output  DATA_W; muxed data to wvb_reader.
REQ-013 rdr_hdr_rdreq, rdr_wvb_rdreq, rdr_wvb_rddone  input  1 each  strobes from wvb_reader.
REQ-014 sel_chan  output  3  channel currently granted.
REQ-015 busy  output  1  high while in LOCK state.

Function
REQ-016 FSM states IDLE and LOCK; reset state IDLE.
REQ-017 IDLE -> LOCK when en=1 and any ch_hdr_empty bit is 0; sel_chan registered to the first non-empty channel searching from rr_ptr upward, modulo N_CHAN.
REQ-018 Grant latency: 1 clk from the non-empty condition in IDLE to busy=1 and rdr_hdr_empty reflecting the granted channel.
REQ-019 rdr_hdr_empty = 1 in IDLE; in LOCK = ch_hdr_empty[sel_chan] (combinational).
REQ-020 rdr_hdr_data, rdr_wvb_data combinationally muxed from sel_chan at all times.
REQ-021 In LOCK, rdr_hdr_rdreq, rdr_wvb_rdreq, rdr_wvb_rddone route combinationally to bit sel_chan of the ch_* strobes; all other bits 0; in IDLE all ch_* strobes are 0.
REQ-022 LOCK -> IDLE on rdr_wvb_rddone=1; same edge sets rr_ptr to (sel_chan+1) mod N_CHAN.
REQ-023 At least one IDLE cycle between consecutive grants, even when rddone coincides with pending requests.
REQ-024 ch_hdr_empty[sel_chan] rising during LOCK does not release the grant; only rddone releases it.
REQ-025 en falling during LOCK has no effect until rddone; no new grant while en=0.
REQ-026 rr_ptr wraps N_CHAN-1 -> 0; with one channel continuously non-empty and the others empty, that channel is re-granted every 2 clk.

Reset
REQ-027 rst asserts asynchronously: state IDLE, rr_ptr 0, sel_chan 0, busy 0, rdr_hdr_empty 1, all ch_* strobes 0.
REQ-028 rst during LOCK aborts the transaction; no ch_wvb_rddone is issued for the aborted channel.
REQ-029 Deassertion is synchronized to clk; first grant no earlier than the 2nd rising edge after rst falls.

Configuration
REQ-030 Macro WVB_ARB_GRANT_CNT_EN: when defined, output grant_cnt (N_CHAN*16) holds per-channel 16-bit counters incremented on each IDLE->LOCK grant to that channel, saturating at 16'hFFFF, cleared by rst.
REQ-031 Without WVB_ARB_GRANT_CNT_EN the grant_cnt port and counters are absent; all other behaviour is identical.

Verification
REQ-032 Reset release, all ch_hdr_empty=4'b1111 -> busy=0, rdr_hdr_empty=1, all ch_* strobes 0 indefinitely.
REQ-033 ch_hdr_empty=4'b0101, rr_ptr=0 -> grants ch1, then ch3, then ch1 after each rddone; sel_chan sequence 1,3,1.
REQ-034 Granted ch2, rdr_wvb_rdreq pulsed 5 times -> ch_wvb_rdreq=4'b0100 exactly 5 cycles, other bits never set; rdr_wvb_data equals ch2 data.
REQ-035 rddone with ch_hdr_empty=4'b0000 -> one IDLE cycle (busy=0), then next channel granted.
REQ-036 en=0 with ch_hdr_empty=4'b1110 -> no grant; en=1 -> busy=1 after 1 clk, sel_chan=0.
REQ-037 rst pulsed mid-LOCK on ch3 -> immediate busy=0, rdr_hdr_empty=1, no ch_wvb_rddone; with WVB_ARB_GRANT_CNT_EN, grant_cnt reads 0.
